// File: rtl/nn_pkg.sv
// Shared types and helpers for the neural-net datapath blocks.
// Node values are signed 8-bit, products from mul are signed 16-bit.
package nn_pkg;
  localparam int NODE_W   = 8;
  localparam int PROD_W   = 16;
  localparam int SAT_IN_W = 32;

  typedef enum logic {S_ACC, S_OUT} state_e;

  // Clamp a non-negative value to the positive node range 0..127.
  function automatic logic [NODE_W-1:0] sat127(input logic [SAT_IN_W-1:0] y);
    return (y > SAT_IN_W'(127)) ? NODE_W'(127) : y[NODE_W-1:0];
  endfunction
endpackage

// File: rtl/neuron_acc_if.sv
// Product-in / node-out handshake bundle for neuron_acc.
// master = upstream/downstream environment, slave = neuron_acc.
interface neuron_acc_if;
  import nn_pkg::*;

  logic                     i_valid;
  logic                     i_ready;
  logic signed [PROD_W-1:0] i_mul;
  logic signed [NODE_W-1:0] i_bias;
  logic                     o_valid;
  logic                     o_ready;
  logic        [NODE_W-1:0] o_node;

  modport master (
    output i_valid, i_mul, i_bias, o_ready,
    input  i_ready, o_valid, o_node
  );

  modport slave (
    input  i_valid, i_mul, i_bias, o_ready,
    output i_ready, o_valid, o_node
  );
endinterface

// File: rtl/neuron_acc_relu_sat.sv
// Combinational activation: ReLU, arithmetic right shift by SHIFT, clamp to 0..127.
// Since the value is non-negative after ReLU, a logical shift gives the same result.
module relu_sat
  import nn_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0]  sum_i,
  output logic        [NODE_W-1:0] node_o
);
  logic [ACC_W-1:0] relu_v;
  logic [ACC_W-1:0] shifted;
  logic             wide_ovf;

  always_comb begin
    relu_v   = sum_i[ACC_W-1] ? '0 : sum_i;
    shifted  = relu_v >> SHIFT;
    // Bits beyond the helper's input width can only mean "too big".
    wide_ovf = |(shifted >> SAT_IN_W);
    node_o   = wide_ovf ? NODE_W'(127) : sat127(SAT_IN_W'(shifted));
  end
endmodule

// File: rtl/neuron_acc.sv
// Sums N_IN signed products plus a per-neuron bias, then ReLU/shift/saturate to a node value.
// Result registered on the N_IN-th accept; i_ready drops for the single holding state until o_ready.
module neuron_acc
  import nn_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int ACC_W = 24,
  parameter int SHIFT = 7
) (
  input logic         clk,
  input logic         rst,
  neuron_acc_if.slave bus
);
  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [NODE_W-1:0] bias_q, bias_d;
  logic                     o_valid_q, o_valid_d;
  logic [NODE_W-1:0]        o_node_q, o_node_d;

  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  sum;
  logic [NODE_W-1:0]        node_nxt;
  logic                     last_beat;

  assign prod_ext  = {{(ACC_W-PROD_W){bus.i_mul[PROD_W-1]}}, bus.i_mul};
  assign bias_ext  = {{(ACC_W-NODE_W){bias_q[NODE_W-1]}}, bias_q};
  assign sum       = acc_q + prod_ext + bias_ext;
  assign last_beat = (count_q == CNT_W'(N_IN-1));

  relu_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_relu_sat (
    .sum_i  (sum),
    .node_o (node_nxt)
  );

  assign bus.i_ready = (state_q == S_ACC);
  assign bus.o_valid = o_valid_q;
  assign bus.o_node  = o_node_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    bias_d    = bias_q;
    o_valid_d = o_valid_q;
    o_node_d  = o_node_q;
    case (state_q)
      S_ACC: begin
        if (bus.i_valid) begin
          // N_IN >= 2, so the first beat is never also the last one.
          if (count_q == '0) begin
            acc_d   = prod_ext;
            bias_d  = bus.i_bias;
            count_d = CNT_W'(1);
          end else if (last_beat) begin
            o_node_d  = node_nxt;
            o_valid_d = 1'b1;
            count_d   = '0;
            state_d   = S_OUT;
          end else begin
            acc_d   = acc_q + prod_ext;
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      S_OUT: begin
        if (bus.o_ready) begin
          o_valid_d = 1'b0;
          state_d   = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ACC;
      count_q   <= '0;
      acc_q     <= '0;
      bias_q    <= '0;
      o_valid_q <= 1'b0;
      o_node_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      bias_q    <= bias_d;
      o_valid_q <= o_valid_d;
      o_node_q  <= o_node_d;
    end
  end
endmodule

// File: tb/tb_neuron_acc.sv
// Bench: three neuron_acc instances (SHIFT 7, 4, 0) share one stimulus stream;
// a queue-based scoreboard checks every delivered node against a plain-arithmetic model.
module tb_neuron_acc;
  import nn_pkg::*;

  localparam int N = 4;

  typedef struct packed {
    logic [7:0] n7;
    logic [7:0] n4;
    logic [7:0] n0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [15:0] i_mul = '0;
  logic [7:0]  i_bias = '0;
  logic        o_ready = 1'b1;
  bit          rand_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int n_results = 0;
  int n_expected = 0;
  exp_t exp_q[$];
  int part_sum = 0;
  int part_n = 0;
  int part_bias = 0;

  always #5 clk = ~clk;

  neuron_acc_if bus7();
  neuron_acc_if bus4();
  neuron_acc_if bus0();

  assign bus7.i_valid = i_valid;
  assign bus7.i_mul   = i_mul;
  assign bus7.i_bias  = i_bias;
  assign bus7.o_ready = o_ready;
  assign bus4.i_valid = i_valid;
  assign bus4.i_mul   = i_mul;
  assign bus4.i_bias  = i_bias;
  assign bus4.o_ready = o_ready;
  assign bus0.i_valid = i_valid;
  assign bus0.i_mul   = i_mul;
  assign bus0.i_bias  = i_bias;
  assign bus0.o_ready = o_ready;

  neuron_acc #(.N_IN(N), .ACC_W(24), .SHIFT(7)) dut7 (.clk(clk), .rst(rst), .bus(bus7));
  neuron_acc #(.N_IN(N), .ACC_W(24), .SHIFT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  neuron_acc #(.N_IN(N), .ACC_W(24), .SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_node(input int s, input int sh);
    int r;
    r = (s < 0) ? 0 : s;
    r = r >>> sh;
    if (r > 127) r = 127;
    return 8'(r);
  endfunction

  task automatic model_accept(input int m, input int b);
    exp_t e;
    int   s;
    if (part_n == 0) part_bias = b;
    part_sum += m;
    part_n++;
    if (part_n == N) begin
      s    = part_sum + part_bias;
      e.n7 = ref_node(s, 7);
      e.n4 = ref_node(s, 4);
      e.n0 = ref_node(s, 0);
      exp_q.push_back(e);
      n_expected++;
      part_sum = 0;
      part_n   = 0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until the DUT takes it; returns edges spent.
  task automatic send_beat(input int m, input int b, output int edges);
    logic took;
    edges   = 0;
    took    = 1'b0;
    i_valid = 1'b1;
    i_mul   = 16'(m);
    i_bias  = 8'(b);
    while (!took && edges < 50) begin
      @(negedge clk);
      took = bus7.i_ready;
      @(posedge clk);
      #1;
      edges++;
    end
    chk("beat_accept", int'(took), 1);
    if (took) model_accept(m, b);
    i_valid = 1'b0;
  endtask

  task automatic send_neuron(input int m, input int b);
    int e;
    for (int k = 0; k < N; k++) send_beat(m, b, e);
  endtask

  task automatic drop_pending();
    n_expected -= exp_q.size();
    exp_q.delete();
    part_sum = 0;
    part_n   = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus7.o_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got node %0d, expected no result", bus7.o_node);
      end else begin
        chk("node_s7", bus7.o_node, exp_q[0].n7);
        chk("node_s4", bus4.o_node, exp_q[0].n4);
        chk("node_s0", bus0.o_node, exp_q[0].n0);
        chk("valid_s4", bus4.o_valid, 1);
        chk("valid_s0", bus0.o_valid, 1);
        if (o_ready) begin
          void'(exp_q.pop_front());
          n_results++;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) o_ready = ($urandom_range(0, 2) != 0);
  end

  initial begin
    int e;
    int tot;
    int m;
    int b;
    logic [7:0] held;

    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_i_ready", bus7.i_ready, 1);
    chk("rst_o_valid", bus7.o_valid, 0);
    chk("rst_node_s7", bus7.o_node, 0);
    chk("rst_node_s0", bus0.o_node, 0);
    @(posedge clk);
    #1;

    // Nominal, negative clamp, saturation
    send_neuron(2500, -101);
    chk("nom_valid_next", bus7.o_valid, 1);
    chk("nom_node_s7", bus7.o_node, 77);
    step(1);
    send_neuron(-2500, 50);
    chk("neg_node_s7", bus7.o_node, 0);
    chk("neg_valid", bus7.o_valid, 1);
    step(1);
    send_neuron(2500, 0);
    chk("sat_node_s4", bus4.o_node, 127);
    step(1);

    // Backpressure: result must hold while extra beats are offered
    o_ready = 1'b0;
    send_neuron(int'($urandom_range(0, 800)) - 200, int'($urandom_range(0, 255)) - 128);
    held = bus7.o_node;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_mul   = 16'($urandom_range(0, 65535));
      i_bias  = 8'($urandom_range(0, 255));
      @(negedge clk);
      chk("bp_i_ready", bus7.i_ready, 0);
      chk("bp_o_valid", bus7.o_valid, 1);
      chk("bp_node_hold", bus7.o_node, held);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    step(1);
    chk("bp_release_valid", bus7.o_valid, 0);
    chk("bp_release_ready", bus7.i_ready, 1);

    // Reset mid-accumulation discards the partial sum
    send_beat(2500, 5, e);
    send_beat(2500, 5, e);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    drop_pending();
    chk("rstmid_i_ready", bus7.i_ready, 1);
    send_neuron(100, 28);
    chk("rstmid_node_s0", bus0.o_node, 127);
    step(1);
    send_neuron(20, 7);
    chk("rstmid2_node_s0", bus0.o_node, 87);
    step(1);

    // Reset while holding a result drops it
    o_ready = 1'b0;
    send_neuron(300, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    drop_pending();
    chk("rst_out_valid", bus7.o_valid, 0);
    o_ready = 1'b1;

    // Back-to-back: two neurons in ten cycles, one stall each
    tot = 0;
    for (int k = 0; k < 2 * N; k++) begin
      m = int'($urandom_range(0, 1000)) - 300;
      send_beat(m, 3 * k - 10, e);
      tot += e;
      if (k == N) chk("b2b_stall_edges", e, 2);
    end
    chk("b2b_beat_edges", tot, 2 * N + 1);
    chk("b2b_valid", bus7.o_valid, 1);
    chk("b2b_ready_low", bus7.i_ready, 0);
    step(1);
    chk("b2b_pulse_end", bus7.o_valid, 0);
    chk("b2b_ready_back", bus7.i_ready, 1);

    // Randomized neurons with gaps and random downstream stalls
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      b = int'($urandom_range(0, 255)) - 128;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) step(int'($urandom_range(1, 2)));
        if ($urandom_range(0, 3) == 0) m = int'($urandom_range(0, 65535)) - 32768;
        else m = int'($urandom_range(0, 1200)) - 600;
        send_beat(m, (k == 0) ? b : int'($urandom_range(0, 255)) - 128, e);
      end
    end
    rand_ready = 1'b0;
    o_ready = 1'b1;

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) step(1);
    chk("drain_empty", exp_q.size(), 0);
    chk("result_count", n_results, n_expected);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
